// File: rtl/vx_dispatch_router.sv
// Purpose: routes one issued packet per cycle into NUM_UNITS per-unit FIFOs selected by in_type.
// Latency: a packet accepted at edge N is visible at its unit output in cycle N+1; there is no bypass.
// Backpressure: in_ready drops when the target queue is full or flush is high; illegal types are always taken and dropped.
// Optional feature: define VX_DISPATCH_PERF_EN to add the per-unit stall counters on perf_stalls.
module vx_dispatch_router #(
    parameter int NUM_UNITS     = 4,
    parameter int DATAW         = 64,
    parameter int DEPTH         = 4,
    parameter int TYPE_W        = $clog2(NUM_UNITS),
    parameter int CNT_W         = $clog2(DEPTH + 1),
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [TYPE_W-1:0]             in_type,
    input  logic [DATAW-1:0]              in_data,
    output logic [NUM_UNITS-1:0]          out_valid,
    output logic [NUM_UNITS*DATAW-1:0]    out_data,
    input  logic [NUM_UNITS-1:0]          out_ready,
    output logic [NUM_UNITS*CNT_W-1:0]    occupancy,
    output logic                          type_err
`ifdef VX_DISPATCH_PERF_EN
    ,
    output logic [NUM_UNITS*PERF_CTR_BITS-1:0] perf_stalls
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    if (NUM_UNITS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PERF_CTR_BITS < 1) begin : g_cfg_check
        $error("vx_dispatch_router: unsupported parameter set");
    end

    logic [CNT_W-1:0] count_q [NUM_UNITS];
    logic [CNT_W-1:0] count_d [NUM_UNITS];
    logic [PTR_W-1:0] wptr_q  [NUM_UNITS];
    logic [PTR_W-1:0] wptr_d  [NUM_UNITS];
    logic [PTR_W-1:0] rptr_q  [NUM_UNITS];
    logic [PTR_W-1:0] rptr_d  [NUM_UNITS];
    logic [DATAW-1:0] mem_q   [NUM_UNITS][DEPTH];
    logic             type_err_q;
    logic             type_err_d;
    logic             type_legal;
    logic             sel_full;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;

    // Input readiness from the selected queue's current count, plus per-unit push/pop decode.
    always_comb begin
        type_legal = (32'(in_type) < NUM_UNITS);
        sel_full   = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (in_type == TYPE_W'(u)) begin
                sel_full = (count_q[u] == CNT_W'(DEPTH));
            end
        end
        // Illegal types are swallowed so a bad packet can never wedge the issue stage.
        in_ready = type_legal ? (!sel_full && !flush) : 1'b1;
        for (int u = 0; u < NUM_UNITS; u++) begin
            push[u] = in_valid && in_ready && !flush && (in_type == TYPE_W'(u));
            pop[u]  = (count_q[u] != '0) && out_ready[u] && !flush;
        end
    end

    // Next-state pointers, counts and sticky error; flush discards this cycle's push and pop.
    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        type_err_d = type_err_q || (in_valid && in_ready && !type_legal);
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (flush) begin
                count_d[u] = '0;
                wptr_d[u]  = '0;
                rptr_d[u]  = '0;
            end else begin
                if (push[u]) wptr_d[u] = wptr_q[u] + PTR_W'(1);
                if (pop[u])  rptr_d[u] = rptr_q[u] + PTR_W'(1);
                if (push[u] && !pop[u]) count_d[u] = count_q[u] + CNT_W'(1);
                if (pop[u] && !push[u]) count_d[u] = count_q[u] - CNT_W'(1);
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                count_q[u] <= '0;
                wptr_q[u]  <= '0;
                rptr_q[u]  <= '0;
            end
            type_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            type_err_q <= type_err_d;
        end
    end

    // Payload storage; not reset because validity is tracked by the counts alone.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (push[u]) mem_q[u][wptr_q[u]] <= in_data;
        end
    end

    // Flatten per-unit head, valid and occupancy onto the output buses.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        occupancy = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            out_valid[u]                      = (count_q[u] != '0);
            out_data[u*DATAW +: DATAW]        = mem_q[u][rptr_q[u]];
            occupancy[u*CNT_W +: CNT_W]       = count_q[u];
        end
        type_err = type_err_q;
    end

`ifdef VX_DISPATCH_PERF_EN
    logic [PERF_CTR_BITS-1:0] stall_q [NUM_UNITS];
    logic [PERF_CTR_BITS-1:0] stall_d [NUM_UNITS];

    // Count cycles a valid packet waits on its unit, including waits caused by flush.
    always_comb begin
        stall_d     = stall_q;
        perf_stalls = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (in_valid && !in_ready && (in_type == TYPE_W'(u))) begin
                stall_d[u] = stall_q[u] + PERF_CTR_BITS'(1);
            end
            perf_stalls[u*PERF_CTR_BITS +: PERF_CTR_BITS] = stall_q[u];
        end
    end

    // Stall counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) stall_q[u] <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_vx_dispatch_router.sv
// Bench for vx_dispatch_router: a 4-unit instance checked against a queue model,
// plus a 3-unit instance used for the illegal-type path.
module tb_vx_dispatch_router;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int PB = 44;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, flush, in_valid, in_ready, type_err;
    logic [1:0]      in_type;
    logic [DW-1:0]   in_data;
    logic [N-1:0]    out_valid, out_ready;
    logic [N*DW-1:0] out_data;
    logic [N*CW-1:0] occupancy;

    logic            b_flush, b_in_valid, b_in_ready, b_type_err;
    logic [1:0]      b_in_type;
    logic [DW-1:0]   b_in_data;
    logic [2:0]      b_out_valid, b_out_ready;
    logic [3*DW-1:0] b_out_data;
    logic [3*CW-1:0] b_occupancy;
`ifdef VX_DISPATCH_PERF_EN
    logic [N*PB-1:0] perf_stalls;
    logic [3*PB-1:0] b_perf_stalls;
`endif

    vx_dispatch_router #(.NUM_UNITS(N), .DATAW(DW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy), .type_err(type_err)
`ifdef VX_DISPATCH_PERF_EN
        , .perf_stalls(perf_stalls)
`endif
    );

    vx_dispatch_router #(.NUM_UNITS(3), .DATAW(DW), .DEPTH(D)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_type(b_in_type), .in_data(b_in_data), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(b_out_ready), .occupancy(b_occupancy), .type_err(b_type_err)
`ifdef VX_DISPATCH_PERF_EN
        , .perf_stalls(b_perf_stalls)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one in-order queue per unit plus stall tallies.
    logic [DW-1:0] mq [N][$];
    longint        stalls [N];

    function automatic bit exp_ready();
        return !flush && (mq[in_type].size() < D);
    endfunction

    function automatic logic [N-1:0] exp_vld();
        logic [N-1:0] v;
        for (int u = 0; u < N; u++) v[u] = (mq[u].size() != 0);
        return v;
    endfunction

    function automatic logic [N*CW-1:0] exp_occ();
        logic [N*CW-1:0] o;
        for (int u = 0; u < N; u++) o[u*CW +: CW] = CW'(mq[u].size());
        return o;
    endfunction

    // Advance one clock and apply the specification's rules to the model.
    task automatic tick();
        bit           rdy = exp_ready();
        logic         v   = in_valid;
        logic         f   = flush;
        logic         r   = reset;
        logic [1:0]   t   = in_type;
        logic [DW-1:0] d  = in_data;
        logic [N-1:0] o   = out_ready;
        @(posedge clk);
        if (r) begin
            for (int u = 0; u < N; u++) begin
                mq[u].delete();
                stalls[u] = 0;
            end
        end else begin
            for (int u = 0; u < N; u++) if (v && !rdy && int'(t) == u) stalls[u]++;
            if (f) begin
                for (int u = 0; u < N; u++) mq[u].delete();
            end else begin
                for (int u = 0; u < N; u++) if (mq[u].size() != 0 && o[u]) void'(mq[u].pop_front());
                if (v && rdy) mq[t].push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 4'b0) $display("FAIL reset_out_valid got %b want %b", out_valid, 4'b0); else n_pass++;
        n_checks++; if (occupancy !== 12'b0) $display("FAIL reset_occupancy got %h want %h", occupancy, 12'b0); else n_pass++;
        n_checks++; if (type_err !== 1'b0) $display("FAIL reset_type_err got %b want 0", type_err); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (b_out_valid !== 3'b0 || b_type_err !== 1'b0) $display("FAIL reset_b got vld=%b err=%b want 0/0", b_out_valid, b_type_err); else n_pass++;
`ifdef VX_DISPATCH_PERF_EN
        n_checks++; if (perf_stalls !== '0) $display("FAIL reset_perf got %h want 0", perf_stalls); else n_pass++;
`endif
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_type = 2'd2; in_data = 16'h00A5;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 4'b0) $display("FAIL single_no_bypass got %b want 0000", out_valid); else n_pass++;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 4'b0100) $display("FAIL single_out_valid got %b want 0100", out_valid); else n_pass++;
        n_checks++; if (occupancy[2*CW +: CW] !== 3'd1) $display("FAIL single_occ got %0d want 1", occupancy[2*CW +: CW]); else n_pass++;
        n_checks++; if (out_data[2*DW +: DW] !== 16'h00A5) $display("FAIL single_data got %h want 00a5", out_data[2*DW +: DW]); else n_pass++;
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0;
        #1;
        n_checks++; if (out_valid !== 4'b0 || occupancy !== 12'b0) $display("FAIL single_drain got vld=%b occ=%h want 0/0", out_valid, occupancy); else n_pass++;
    endtask

    task automatic test_fill_stall();
        logic [DW-1:0] got [5];
        out_ready = 4'b0;
        in_valid  = 1'b1;
        in_type   = 2'd1;
        for (int k = 0; k < 4; k++) begin
            in_data = 16'(16'h10 + k);
            #1;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL fill_ready[%0d] got %b want 1", k, in_ready); else n_pass++;
            tick();
        end
        in_data = 16'h0014;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_stall got %b want 0", in_ready); else n_pass++;
        n_checks++; if (occupancy[CW +: CW] !== 3'd4) $display("FAIL full_occ got %0d want 4", occupancy[CW +: CW]); else n_pass++;
        tick();
`ifdef VX_DISPATCH_PERF_EN
        n_checks++; if (perf_stalls[PB +: PB] !== 44'd1) $display("FAIL perf_one_stall got %0d want 1", perf_stalls[PB +: PB]); else n_pass++;
`endif
        in_type = 2'd0; in_data = 16'h0077;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL other_unit_ready got %b want 1", in_ready); else n_pass++;
        tick();
        // Full unit 1 draining while a type-1 push waits.
        in_type = 2'd1; in_data = 16'h0014; out_ready = 4'b0010;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL drain_c1_ready got %b want 0", in_ready); else n_pass++;
        got[0] = out_data[DW +: DW];
        tick();
        #1;
        n_checks++; if (occupancy[CW +: CW] !== 3'd3) $display("FAIL drain_c1_occ got %0d want 3", occupancy[CW +: CW]); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL drain_c2_ready got %b want 1", in_ready); else n_pass++;
        got[1] = out_data[DW +: DW];
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (occupancy[CW +: CW] !== 3'd3) $display("FAIL drain_c2_occ got %0d want 3", occupancy[CW +: CW]); else n_pass++;
        for (int k = 2; k < 5; k++) begin
            #1;
            got[k] = out_data[DW +: DW];
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (got[k] !== 16'(16'h10 + k)) $display("FAIL order[%0d] got %h want %h", k, got[k], 16'(16'h10 + k)); else n_pass++;
        end
        out_ready = 4'b0001;
        tick();
        out_ready = 4'b0;
        #1;
        n_checks++; if (out_valid !== exp_vld() || occupancy !== exp_occ()) $display("FAIL fill_end got vld=%b occ=%h want vld=%b occ=%h", out_valid, occupancy, exp_vld(), exp_occ()); else n_pass++;
`ifdef VX_DISPATCH_PERF_EN
        n_checks++; if (perf_stalls[PB +: PB] !== 44'(stalls[1])) $display("FAIL perf_after_drain got %0d want %0d", perf_stalls[PB +: PB], stalls[1]); else n_pass++;
`endif
    endtask

    task automatic test_wrap();
        logic [DW-1:0] got [$];
        out_ready = 4'b1000;
        in_type   = 2'd3;
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 10);
            in_data  = 16'(16'h30 + c);
            #1;
            if (c == 0) begin
                n_checks++; if (out_valid[3] !== 1'b0) $display("FAIL wrap_first_vld got %b want 0", out_valid[3]); else n_pass++;
            end
            n_checks++; if (occupancy[3*CW +: CW] > 3'd1) $display("FAIL wrap_occ[%0d] got %0d want <=1", c, occupancy[3*CW +: CW]); else n_pass++;
            if (out_valid[3] === 1'b1) got.push_back(out_data[3*DW +: DW]);
            tick();
        end
        in_valid = 1'b0; out_ready = 4'b0;
        n_checks++; if (got.size() !== 10) $display("FAIL wrap_count got %0d want 10", got.size()); else n_pass++;
        for (int k = 0; k < 10 && k < got.size(); k++) begin
            n_checks++; if (got[k] !== 16'(16'h30 + k)) $display("FAIL wrap_data[%0d] got %h want %h", k, got[k], 16'(16'h30 + k)); else n_pass++;
        end
    endtask

    task automatic test_illegal();
        b_in_valid = 1'b1; b_in_type = 2'd3; b_in_data = 16'hBEEF;
        #1;
        n_checks++; if (b_in_ready !== 1'b1) $display("FAIL illegal_ready got %b want 1", b_in_ready); else n_pass++;
        tick();
        b_in_valid = 1'b0;
        #1;
        n_checks++; if (b_out_valid !== 3'b0 || b_occupancy !== 9'b0) $display("FAIL illegal_dropped got vld=%b occ=%h want 0/0", b_out_valid, b_occupancy); else n_pass++;
        n_checks++; if (b_type_err !== 1'b1) $display("FAIL illegal_err got %b want 1", b_type_err); else n_pass++;
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        #1;
        n_checks++; if (b_type_err !== 1'b1) $display("FAIL illegal_err_after_flush got %b want 1", b_type_err); else n_pass++;
    endtask

    task automatic fill_pattern();
        out_ready = 4'b0;
        in_valid = 1'b1; in_type = 2'd0; in_data = 16'h0001; tick();
        in_data = 16'h0002; tick();
        in_type = 2'd2; in_data = 16'h0003; tick();
        in_valid = 1'b0;
    endtask

    task automatic test_flush_reset();
        fill_pattern();
        #1;
        n_checks++; if (occupancy !== {3'd0, 3'd1, 3'd0, 3'd2}) $display("FAIL flush_pre_occ got %h want %h", occupancy, {3'd0, 3'd1, 3'd0, 3'd2}); else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_type = 2'd1; in_data = 16'h00FF; out_ready = 4'b0101;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 4'b0;
        #1;
        n_checks++; if (out_valid !== 4'b0 || occupancy !== 12'b0) $display("FAIL flush_empty got vld=%b occ=%h want 0/0", out_valid, occupancy); else n_pass++;
        fill_pattern();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 4'b0 || occupancy !== 12'b0) $display("FAIL reset_empty got vld=%b occ=%h want 0/0", out_valid, occupancy); else n_pass++;
        n_checks++; if (b_type_err !== 1'b0) $display("FAIL reset_clears_err got %b want 0", b_type_err); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_type   = 2'($urandom_range(0, 3));
            in_data   = 16'($urandom);
            out_ready = (c < 200) ? 4'($urandom & $urandom) : 4'($urandom);
            flush     = ($urandom_range(0, 24) == 0);
            #1;
            n_checks++; if (in_ready !== exp_ready()) $display("FAIL rnd_ready[%0d] got %b want %b", c, in_ready, exp_ready()); else n_pass++;
            n_checks++; if (out_valid !== exp_vld()) $display("FAIL rnd_vld[%0d] got %b want %b", c, out_valid, exp_vld()); else n_pass++;
            n_checks++; if (occupancy !== exp_occ()) $display("FAIL rnd_occ[%0d] got %h want %h", c, occupancy, exp_occ()); else n_pass++;
            for (int u = 0; u < N; u++) begin
                if (mq[u].size() != 0) begin
                    n_checks++; if (out_data[u*DW +: DW] !== mq[u][0]) $display("FAIL rnd_head[%0d] u%0d got %h want %h", c, u, out_data[u*DW +: DW], mq[u][0]); else n_pass++;
                end
`ifdef VX_DISPATCH_PERF_EN
                n_checks++; if (perf_stalls[u*PB +: PB] !== 44'(stalls[u])) $display("FAIL rnd_perf[%0d] u%0d got %0d want %0d", c, u, perf_stalls[u*PB +: PB], stalls[u]); else n_pass++;
`endif
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 4'b0;
        #1;
        n_checks++; if (type_err !== 1'b0) $display("FAIL rnd_type_err got %b want 0", type_err); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = 2'd0; in_data = '0; out_ready = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_type = 2'd0; b_in_data = '0; b_out_ready = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_stall();
        test_wrap();
        test_illegal();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
